// File: rtl/nios2_mult_pkg.sv
// Shared constants, helper function and stage record for the Nios II multiply cell.
package nios2_mult_pkg;

  localparam int DEF_WIDTH_A      = 32;
  localparam int DEF_WIDTH_B      = 32;
  localparam int DEF_WIDTH_RESULT = 64;
  localparam int PIPE_STAGES_MAX  = 4;

  // Operands gain one bit so unsigned values survive a signed multiply.
  function automatic int ext_width(input int w);
    return w + 1;
  endfunction

  typedef struct packed {
    logic                        valid;
    logic [DEF_WIDTH_RESULT-1:0] product;
  } mult_stage_t;

endpackage

// File: rtl/nios2_mult_pipe_stage.sv
// One product pipeline register: enable-gated data, valid bit with flush-clear.
module nios2_mult_pipe_stage
  import nios2_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH_RESULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_d,
  input  logic [WIDTH-1:0] data_d,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush)   valid_q <= 1'b0;
      else if (en) valid_q <= valid_d;
      if (en)      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/nios2_mult_cell_pipe.sv
// Pipelined signed/unsigned multiply cell with flush and split M/A-stage stalls.
// Optional accumulate mode is enabled with the MULT_CELL_PIPE_ACC_EN macro.
module nios2_mult_cell_pipe
  import nios2_mult_pkg::*;
#(
  parameter int WIDTH_A      = DEF_WIDTH_A,
  parameter int WIDTH_B      = DEF_WIDTH_B,
  parameter int PIPE_STAGES  = 0,
  parameter int WIDTH_RESULT = WIDTH_A + WIDTH_B
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic [WIDTH_A-1:0]      src_a,
  input  logic [WIDTH_B-1:0]      src_b,
  input  logic                    sign_a,
  input  logic                    sign_b,
  input  logic                    en_in,
  input  logic                    en_out,
  input  logic                    flush,
`ifdef MULT_CELL_PIPE_ACC_EN
  input  logic                    acc_en,
  input  logic                    acc_clr,
`endif
  output logic [WIDTH_RESULT-1:0] result,
  output logic                    out_valid,
  output logic                    busy
);

  localparam int PROD_W = ext_width(WIDTH_A) + ext_width(WIDTH_B);
`ifdef MULT_CELL_PIPE_ACC_EN
  localparam int ACC_W = 2;
`else
  localparam int ACC_W = 0;
`endif
  localparam int DATA_W = WIDTH_RESULT + ACC_W;

  logic [WIDTH_A-1:0] s0_a;
  logic [WIDTH_B-1:0] s0_b;
  logic               s0_sign_a, s0_sign_b, s0_valid;
`ifdef MULT_CELL_PIPE_ACC_EN
  logic               s0_acc_en, s0_acc_clr;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_a      <= '0;
      s0_b      <= '0;
      s0_sign_a <= 1'b0;
      s0_sign_b <= 1'b0;
      s0_valid  <= 1'b0;
`ifdef MULT_CELL_PIPE_ACC_EN
      s0_acc_en  <= 1'b0;
      s0_acc_clr <= 1'b0;
`endif
    end else begin
      if (flush)      s0_valid <= 1'b0;
      else if (en_in) s0_valid <= in_valid;
      if (en_in) begin
        s0_a      <= src_a;
        s0_b      <= src_b;
        s0_sign_a <= sign_a;
        s0_sign_b <= sign_b;
`ifdef MULT_CELL_PIPE_ACC_EN
        s0_acc_en  <= acc_en;
        s0_acc_clr <= acc_clr;
`endif
      end
    end
  end

  // Both operands widened to the full product width before the signed multiply.
  logic signed [PROD_W-1:0] wide_a, wide_b, prod_full;
  assign wide_a    = {{(PROD_W-WIDTH_A){s0_sign_a & s0_a[WIDTH_A-1]}}, s0_a};
  assign wide_b    = {{(PROD_W-WIDTH_B){s0_sign_b & s0_b[WIDTH_B-1]}}, s0_b};
  assign prod_full = wide_a * wide_b;

  logic [WIDTH_RESULT-1:0] product;
  if (WIDTH_RESULT > PROD_W) begin : g_sext
    assign product = {{(WIDTH_RESULT-PROD_W){prod_full[PROD_W-1]}}, prod_full};
  end else if (WIDTH_RESULT == PROD_W) begin : g_same
    assign product = prod_full;
  end else begin : g_trunc
    assign product = prod_full[WIDTH_RESULT-1:0];
  end

  logic [PIPE_STAGES:0] stage_valid;
  logic [DATA_W-1:0]    stage_data [PIPE_STAGES+1];

  assign stage_valid[0] = s0_valid;
`ifdef MULT_CELL_PIPE_ACC_EN
  assign stage_data[0]  = {s0_acc_clr, s0_acc_en, product};
`else
  assign stage_data[0]  = product;
`endif

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    nios2_mult_pipe_stage #(.WIDTH(DATA_W)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en_in),
      .flush   (flush),
      .valid_d (stage_valid[i]),
      .data_d  (stage_data[i]),
      .valid_q (stage_valid[i+1]),
      .data_q  (stage_data[i+1])
    );
  end

  logic                    last_valid;
  logic [WIDTH_RESULT-1:0] last_product;
  logic [WIDTH_RESULT-1:0] next_result;

  assign last_valid   = stage_valid[PIPE_STAGES];
  assign last_product = stage_data[PIPE_STAGES][WIDTH_RESULT-1:0];
  assign busy         = |stage_valid;

`ifdef MULT_CELL_PIPE_ACC_EN
  logic last_acc_en, last_acc_clr, consumed;
  assign last_acc_en  = stage_data[PIPE_STAGES][WIDTH_RESULT];
  assign last_acc_clr = stage_data[PIPE_STAGES][WIDTH_RESULT+1];

  // The last stage has already been delivered once unless the pipe advanced since.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    consumed <= 1'b0;
    else if (en_in)  consumed <= 1'b0;
    else if (en_out) consumed <= 1'b1;
  end

  always_comb begin
    next_result = last_product;
    if (consumed)                      next_result = result;
    else if (last_valid && last_acc_clr) next_result = last_product;
    else if (last_valid && last_acc_en)  next_result = result + last_product;
  end
`else
  assign next_result = last_product;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (en_out) out_valid <= last_valid;
      if (en_out)      result    <= next_result;
    end
  end

endmodule

// File: tb/tb_nios2_mult_cell_pipe.sv
// Self-checking bench for nios2_mult_cell_pipe (32x32, two product stages, default build).
module tb_nios2_mult_cell_pipe;

  localparam int P = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        sign_a = 1'b0;
  logic        sign_b = 1'b0;
  logic        en_in = 1'b1;
  logic        en_out = 1'b1;
  logic        flush = 1'b0;
  logic [63:0] result;
  logic        out_valid;
  logic        busy;

  nios2_mult_cell_pipe #(
    .WIDTH_A(32), .WIDTH_B(32), .PIPE_STAGES(P), .WIDTH_RESULT(64)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .src_a     (src_a),
    .src_b     (src_b),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .en_in     (en_in),
    .en_out    (en_out),
    .flush     (flush),
    .result    (result),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sa;
    logic        sb;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb_q[$];
  bit          sb_on = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb);
    logic signed [65:0] xa, xb, p;
    xa = sa ? {{34{a[31]}}, a} : {34'b0, a};
    xb = sb ? {{34{b[31]}}, b} : {34'b0, b};
    p  = xa * xb;
    return p[63:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (sb_on && out_valid) begin
      if (sb_q.size() == 0) check("sb_underflow", {63'b0, out_valid}, 64'd0);
      else                  check("sb_result", result, sb_q.pop_front());
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb);
    src_a  = a;
    src_b  = b;
    sign_a = sa;
    sign_b = sb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rises;
    int          seen;
    logic        prev;
    logic [63:0] exp_a, exp_b, b_result;
    logic [31:0] ra, rb;
    logic        rsa, rsb;

    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0, 64'h0000_0002_FFFF_FFFD});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_8000_0000});
    vecs.push_back('{32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 64'h0000_0000_0000_0000});
    vecs.push_back('{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, 64'h3FFF_FFFF_0000_0001});
    vecs.push_back('{32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, 64'h0000_0000_0000_001E});
    vecs.push_back('{32'h0000_FFFF, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0000_FFFF_0000});
    vecs.push_back('{32'hFFFF_FFFE, 32'h8000_0000, 1'b1, 1'b1, 64'h0000_0001_0000_0000});
    for (int i = 0; i < 6; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      vecs.push_back('{ra, rb, rsa, rsb, model(ra, rb, rsa, rsb)});
    end

    // Reset state while reset is held.
    #12;
    check("reset_result", result, 64'd0);
    check("reset_out_valid", {63'b0, out_valid}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Back-to-back table vectors through the scoreboard.
    sb_on = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb);
      in_valid = 1'b1;
      sb_q.push_back(vecs[i].exp);
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    sb_on = 1'b0;
    for (int i = 0; i < P + 2; i++) step();

    // Stall: op A parked in the last stage, en_in low for three edges with en_out high.
    exp_a = 64'h0000_0002_FFFF_FFFD;
    exp_b = 64'hFFFF_FFFF_FFFF_FFFD;
    rises = 0;
    prev  = out_valid;
    drive(32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    if (out_valid && !prev) rises++;
    prev = out_valid;
    in_valid = 1'b0;
    for (int i = 0; i < P; i++) begin
      step();
      if (out_valid && !prev) rises++;
      prev = out_valid;
    end
    en_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (out_valid && !prev) rises++;
      prev = out_valid;
      check("stall_result", result, exp_a);
      check("stall_out_valid", {63'b0, out_valid}, 64'd1);
    end
    en_in = 1'b1;
    drive(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, 1'b0);
    in_valid = 1'b1;
    b_result = '0;
    step();
    if (out_valid && !prev) rises++;
    prev = out_valid;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid && !prev) begin
        rises++;
        if (rises == 2) b_result = result;
      end
      prev = out_valid;
    end
    check("stall_rises", 64'(rises), 64'd2);
    check("stall_resume_result", b_result, exp_b);

    // Flush together with a new op kills everything in flight.
    drive(32'd11, 32'd12, 1'b0, 1'b0);
    in_valid = 1'b1;
    step();
    drive(32'd13, 32'd14, 1'b0, 1'b0);
    step();
    check("busy_before_flush", {63'b0, busy}, 64'd1);
    drive(32'd15, 32'd16, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_out_valid", {63'b0, out_valid}, 64'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("flush_no_output", 64'(seen), 64'd0);

    // Reset asserted between edges while ops are in flight.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(32'd100 + 32'(i), 32'd7, 1'b0, 1'b0);
      step();
    end
    check("pre_reset_out_valid", {63'b0, out_valid}, 64'd1);
    #3;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midreset_result", result, 64'd0);
    check("midreset_out_valid", {63'b0, out_valid}, 64'd0);
    check("midreset_busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid || busy) seen++;
    end
    check("post_reset_idle", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
